// File: rtl/ram_bist_sequencer.sv
// ============================================================================
// Module   : ram_bist_sequencer
// Brief    : Write/read-back BIST sequencer for one 1-cycle-latency BRAM.
//            Optional macro RAM_BIST_LFSR_PATTERN_EN selects an LFSR pattern.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_bist_sequencer #(
  parameter int BITWIDTH_DATA = 12,
  parameter int BITWIDTH_ADR  = 6,
  parameter int BITWIDTH_ERR  = 16
`ifdef RAM_BIST_LFSR_PATTERN_EN
  ,
  parameter logic [BITWIDTH_DATA-1:0] LFSR_TAPS = 12'h829
`endif
) (
  input  logic                     CLK_SYS,
  input  logic                     RSTN,
  input  logic                     TRGG_START,
  input  logic                     STOP,
  input  logic [BITWIDTH_DATA-1:0] SEED,
  output logic                     RAM_EN,
  output logic                     RAM_WE,
  output logic [BITWIDTH_ADR-1:0]  RAM_ADR,
  output logic [BITWIDTH_DATA-1:0] RAM_DIN,
  input  logic [BITWIDTH_DATA-1:0] RAM_DOUT,
  output logic                     BUSY,
  output logic                     DONE,
  output logic [BITWIDTH_ERR-1:0]  ERR_CNT,
  output logic [BITWIDTH_ADR-1:0]  ERR_FIRST_ADR,
  output logic                     ERR_FLAG
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [BITWIDTH_ADR-1:0] ADR_LAST = '1;

  state_t                   state_q, state_d;
  logic [BITWIDTH_DATA-1:0] seed_q, seed_d;
  logic                     ram_en_q, ram_en_d;
  logic                     ram_we_q, ram_we_d;
  logic [BITWIDTH_ADR-1:0]  ram_adr_q, ram_adr_d;
  logic [BITWIDTH_DATA-1:0] ram_din_q, ram_din_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [BITWIDTH_ERR-1:0]  err_cnt_q, err_cnt_d;
  logic [BITWIDTH_ADR-1:0]  err_first_q, err_first_d;
  logic                     err_flag_q, err_flag_d;
  logic                     chk_vld_q, chk_vld_d;
  logic [BITWIDTH_DATA-1:0] chk_exp_q, chk_exp_d;
  logic [BITWIDTH_ADR-1:0]  chk_adr_q, chk_adr_d;

  logic [BITWIDTH_ADR-1:0]  w_adr_inc;
  logic [BITWIDTH_DATA-1:0] w_pat_start;
  logic [BITWIDTH_DATA-1:0] w_pat_cur;
  logic [BITWIDTH_DATA-1:0] w_pat_next;
  logic                     w_err_hit;

  assign w_adr_inc = ram_adr_q + 1'b1;

`ifdef RAM_BIST_LFSR_PATTERN_EN
  function automatic logic [BITWIDTH_DATA-1:0] lfsr_step(input logic [BITWIDTH_DATA-1:0] s);
    return {s[BITWIDTH_DATA-2:0], ^(s & LFSR_TAPS)};
  endfunction

  // An all-zero state would lock the LFSR, so a zero seed is replaced by 1.
  function automatic logic [BITWIDTH_DATA-1:0] seed_nz(input logic [BITWIDTH_DATA-1:0] s);
    return (s == '0) ? {{(BITWIDTH_DATA-1){1'b0}}, 1'b1} : s;
  endfunction

  logic [BITWIDTH_DATA-1:0] lfsr_q;
  logic                     w_run;
  logic                     w_last;

  assign w_run  = !STOP && (state_q == S_WRITE || state_q == S_READ);
  assign w_last = (ram_adr_q == ADR_LAST);

  always_ff @(posedge CLK_SYS or negedge RSTN) begin
    if (!RSTN) begin
      lfsr_q <= '0;
    end else if (state_q == S_IDLE && TRGG_START && !STOP) begin
      lfsr_q <= seed_nz(SEED);
    end else if (w_run && w_last && state_q == S_WRITE) begin
      lfsr_q <= seed_nz(seed_q);
    end else if (w_run && !w_last) begin
      lfsr_q <= lfsr_step(lfsr_q);
    end
  end

  assign w_pat_start = seed_nz(SEED);
  assign w_pat_cur   = lfsr_q;
  assign w_pat_next  = lfsr_step(lfsr_q);
`else
  function automatic logic [BITWIDTH_DATA-1:0] adr_pattern(input logic [BITWIDTH_ADR-1:0]  a,
                                                           input logic [BITWIDTH_DATA-1:0] s);
    logic [BITWIDTH_ADR+BITWIDTH_DATA-1:0] ext;
    ext = {{BITWIDTH_DATA{1'b0}}, a};
    return ext[BITWIDTH_DATA-1:0] ^ s;
  endfunction

  assign w_pat_start = adr_pattern('0, SEED);
  assign w_pat_cur   = adr_pattern(ram_adr_q, seed_q);
  assign w_pat_next  = adr_pattern(w_adr_inc, seed_q);
`endif

  // The read issued two edges ago is returned on RAM_DOUT in this cycle.
  assign w_err_hit = (state_q == S_READ || state_q == S_DRAIN) && !STOP &&
                     chk_vld_q && (RAM_DOUT != chk_exp_q);

  always_comb begin
    state_d     = state_q;
    seed_d      = seed_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_adr_d   = '0;
    ram_din_d   = '0;
    busy_d      = busy_q;
    done_d      = done_q;
    err_cnt_d   = err_cnt_q;
    err_first_d = err_first_q;
    err_flag_d  = err_flag_q;
    chk_vld_d   = 1'b0;
    chk_exp_d   = chk_exp_q;
    chk_adr_d   = chk_adr_q;

    case (state_q)
      S_IDLE: begin
        if (TRGG_START && !STOP) begin
          state_d     = S_WRITE;
          seed_d      = SEED;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          err_cnt_d   = '0;
          err_first_d = '0;
          err_flag_d  = 1'b0;
          ram_en_d    = 1'b1;
          ram_we_d    = 1'b1;
          ram_din_d   = w_pat_start;
        end
      end
      S_WRITE: begin
        if (STOP) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          ram_en_d = 1'b1;
          if (ram_adr_q == ADR_LAST) begin
            state_d = S_READ;
          end else begin
            ram_we_d  = 1'b1;
            ram_adr_d = w_adr_inc;
            ram_din_d = w_pat_next;
          end
        end
      end
      S_READ: begin
        if (STOP) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          chk_vld_d = 1'b1;
          chk_exp_d = w_pat_cur;
          chk_adr_d = ram_adr_q;
          if (ram_adr_q == ADR_LAST) begin
            state_d = S_DRAIN;
          end else begin
            ram_en_d  = 1'b1;
            ram_adr_d = w_adr_inc;
          end
        end
      end
      S_DRAIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = !STOP;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (w_err_hit) begin
      err_flag_d = 1'b1;
      if (!err_flag_q) begin
        err_first_d = chk_adr_q;
      end
      if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_SYS or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= S_IDLE;
      seed_q      <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_adr_q   <= '0;
      ram_din_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_cnt_q   <= '0;
      err_first_q <= '0;
      err_flag_q  <= 1'b0;
      chk_vld_q   <= 1'b0;
      chk_exp_q   <= '0;
      chk_adr_q   <= '0;
    end else begin
      state_q     <= state_d;
      seed_q      <= seed_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_adr_q   <= ram_adr_d;
      ram_din_q   <= ram_din_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_cnt_q   <= err_cnt_d;
      err_first_q <= err_first_d;
      err_flag_q  <= err_flag_d;
      chk_vld_q   <= chk_vld_d;
      chk_exp_q   <= chk_exp_d;
      chk_adr_q   <= chk_adr_d;
    end
  end

  assign RAM_EN        = ram_en_q;
  assign RAM_WE        = ram_we_q;
  assign RAM_ADR       = ram_adr_q;
  assign RAM_DIN       = ram_din_q;
  assign BUSY          = busy_q;
  assign DONE          = done_q;
  assign ERR_CNT       = err_cnt_q;
  assign ERR_FIRST_ADR = err_first_q;
  assign ERR_FLAG      = err_flag_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_bist_sequencer.sv
// ============================================================================
// Module   : tb_ram_bist_sequencer
// Brief    : Scoreboard bench for ram_bist_sequencer with a 1-cycle BRAM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_bist_sequencer;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        trgg_start = 1'b0;
  logic        stop = 1'b0;
  logic [11:0] seed = '0;
  logic        ram_en, ram_we;
  logic [2:0]  ram_adr;
  logic [11:0] ram_din;
  logic [11:0] ram_dout;
  logic        busy, done, err_flag;
  logic [1:0]  err_cnt;
  logic [2:0]  err_first;

  int total = 0;
  int bad   = 0;

  logic [16:0] bus_q[$];
  logic [7:0]  stat_q[$];
  logic [11:0] mem[N];
  logic [11:0] flip[N];
  logic [11:0] dout_q = '0;
  bit          prev_busy = 0;

  always #5 clk = ~clk;

  ram_bist_sequencer #(
    .BITWIDTH_DATA(12),
    .BITWIDTH_ADR (3),
    .BITWIDTH_ERR (2)
  ) dut (
    .CLK_SYS      (clk),
    .RSTN         (rstn),
    .TRGG_START   (trgg_start),
    .STOP         (stop),
    .SEED         (seed),
    .RAM_EN       (ram_en),
    .RAM_WE       (ram_we),
    .RAM_ADR      (ram_adr),
    .RAM_DIN      (ram_din),
    .RAM_DOUT     (ram_dout),
    .BUSY         (busy),
    .DONE         (done),
    .ERR_CNT      (err_cnt),
    .ERR_FIRST_ADR(err_first),
    .ERR_FLAG     (err_flag)
  );

  // Behavioural BRAM; flip[] corrupts read data to inject mismatches.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_adr] <= ram_din;
      else        dout_q <= mem[ram_adr] ^ flip[ram_adr];
    end
  end
  assign ram_dout = dout_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one bus item per BUSY cycle, one status item when BUSY falls.
  always @(negedge clk) begin
    if (!rstn) begin
      prev_busy = 0;
    end else begin
      if (busy) begin
        if (bus_q.size() == 0) chk("bus_unexpected", {15'd0, ram_en, ram_we, ram_adr, ram_din}, 32'd0);
        else chk("bus", {15'd0, ram_en, ram_we, ram_adr, ram_din}, {15'd0, bus_q.pop_front()});
      end else if (prev_busy) begin
        chk("bus_items_left", bus_q.size(), 0);
        bus_q.delete();
        if (stat_q.size() == 0) chk("stat_unexpected", {24'd0, done, err_cnt, err_first, err_flag, ram_en}, 32'd0);
        else chk("status", {24'd0, done, err_cnt, err_first, err_flag, ram_en}, {24'd0, stat_q.pop_front()});
      end
      prev_busy = busy;
    end
  end

  task automatic ref_patterns(input logic [11:0] s, output logic [11:0] p[N]);
`ifdef RAM_BIST_LFSR_PATTERN_EN
    logic [11:0] v;
    v = (s == 12'd0) ? 12'd1 : s;
    for (int a = 0; a < N; a++) begin
      p[a] = v;
      v = {v[10:0], ^(v & 12'h829)};
    end
`else
    for (int a = 0; a < N; a++) p[a] = 12'(a) ^ s;
`endif
  endtask

  task automatic push_run(input logic [11:0] s, input int stop_at);
    logic [11:0] p[N];
    int n_items, errs, first;
    ref_patterns(s, p);
    n_items = (stop_at > 0) ? stop_at : 2 * N + 1;
    for (int i = 1; i <= n_items; i++) begin
      if (i <= N)          bus_q.push_back({1'b1, 1'b1, 3'(i - 1), p[i-1]});
      else if (i <= 2 * N) bus_q.push_back({1'b1, 1'b0, 3'(i - 1 - N), 12'd0});
      else                 bus_q.push_back(17'd0);
    end
    if (stop_at > 0) begin
      stat_q.push_back(8'd0);
    end else begin
      errs  = 0;
      first = 0;
      for (int a = N - 1; a >= 0; a--) begin
        if (flip[a] != 12'd0) begin
          errs++;
          first = a;
        end
      end
      stat_q.push_back({1'b1, 2'((errs > 3) ? 3 : errs), 3'(first), (errs > 0), 1'b0});
    end
  endtask

  task automatic set_flips(input logic [N-1:0] sel);
    for (int a = 0; a < N; a++) flip[a] = sel[a] ? 12'h001 : 12'h000;
  endtask

  task automatic run(input logic [11:0] s, input int stop_at, input bit mid_start);
    int cyc;
    bit fin;
    push_run(s, stop_at);
    @(negedge clk);
    seed = s;
    trgg_start = 1'b1;
    cyc = 0;
    fin = 0;
    while (!fin && cyc < 40) begin
      @(negedge clk);
      cyc++;
      trgg_start = mid_start && (cyc == 5);
      if (cyc == 1) seed = 12'($urandom);
      stop = (cyc == stop_at);
      if (!busy) fin = 1;
    end
    stop = 1'b0;
    trgg_start = 1'b0;
    if (!fin) chk("busy_timeout", {31'd0, busy}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] sel;
    set_flips('0);
    repeat (3) @(negedge clk);
    chk("reset_outputs", {ram_en, ram_we, ram_adr, ram_din, busy, done, err_cnt, err_first, err_flag}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    run(12'h0A5, 0, 0);
    set_flips(8'b0010_0000);
    run(12'h3C1, 0, 0);
    set_flips(8'b0100_0100);
    run(12'hFFF, 0, 0);
    set_flips(8'b1101_0110);
    run(12'h555, 0, 0);

    set_flips('0);
    run(12'h123, 12, 0);
    run(12'h0A5, 0, 0);
    run(12'h777, 3, 0);

    // Asynchronous reset while writing address 3.
    push_run(12'h2D4, 0);
    @(negedge clk);
    seed = 12'h2D4;
    trgg_start = 1'b1;
    @(negedge clk);
    trgg_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_adr", {29'd0, ram_adr}, 32'd3);
    #2 rstn = 1'b0;
    #1 chk("async_reset_outputs",
           {ram_en, ram_we, ram_adr, ram_din, busy, done, err_cnt, err_first, err_flag}, 32'd0);
    bus_q.delete();
    stat_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Start and stop together must not launch a test.
    trgg_start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    trgg_start = 1'b0;
    stop = 1'b0;
    chk("start_stop_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("start_stop_idle", {30'd0, busy, ram_en}, 32'd0);

    set_flips(8'b0000_1000);
    run(12'h6B2, 0, 1);
    set_flips('0);
    run(12'h000, 0, 0);

    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < N; a++)
        flip[a] = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(1, 4095)) : 12'h000;
      run(12'($urandom), 0, ($urandom_range(0, 1) == 1));
    end
    sel = 8'($urandom);
    set_flips(sel);
    run(12'($urandom), 0, 0);

    repeat (3) @(negedge clk);
    chk("queues_empty", bus_q.size() + stat_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
